// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared widths, stage payload layouts and skid-state encoding
//            for the pipeline stage registers.
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // addi x0, x0, 0 -- the canonical bubble instruction
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
  } ifid_t;

  typedef struct packed {
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [7:0]      ctrl;
  } idex_t;

  typedef struct packed {
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic [3:0]      ctrl;
  } exmem_t;

  typedef struct packed {
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] load_data;
    logic [4:0]      rd;
    logic [2:0]      ctrl;
  } memwb_t;

  localparam int IFID_W  = $bits(ifid_t);
  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

  // Encoded as {skid_valid, main_valid}; 2'b10 is unreachable
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } skid_state_e;

  function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] pc);
    ifid_t b;
    b.instr    = NOP_INSTR;
    b.pc       = pc;
    b.pc_plus4 = pc + XLEN'(4);
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pipe_perf_cnt
// Purpose  : Saturating event counter with enable; sticks at all-ones.
// Revision : 1.0  initial release
// ============================================================================
module pipe_perf_cnt
  import pipe_pkg::*;
#(
  parameter int CNT_W = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Valid/ready pipeline stage register with a 2-entry skid buffer;
//            up_ready and all downstream outputs come straight from flops.
//            Optional build macro PIPE_STAGE_PERF_EN adds stall/flush counters.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = IFID_W,
  parameter logic [DATA_W-1:0] FLUSH_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_up_xfer;
  logic              w_dn_xfer;
  skid_state_e       w_state;

  assign w_up_xfer = up_valid & ~r_skid_valid;
  assign w_dn_xfer = r_main_valid & dn_ready;
  assign w_state   = skid_state_e'({r_skid_valid, r_main_valid});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= FLUSH_DATA;
      r_skid_data  <= FLUSH_DATA;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= FLUSH_DATA;
      r_skid_data  <= FLUSH_DATA;
    end else begin
      case (w_state)
        EMPTY: begin
          if (w_up_xfer) begin
            r_main_valid <= 1'b1;
            r_main_data  <= up_data;
          end
        end
        ONE: begin
          if (w_up_xfer && w_dn_xfer) begin
            r_main_data <= up_data;
          end else if (w_up_xfer) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= up_data;
          end else if (w_dn_xfer) begin
            r_main_valid <= 1'b0;
          end
        end
        default: begin
          // FULL, and the stray 2'b10 encoding which drains its skid entry
          if (w_dn_xfer || !r_main_valid) begin
            r_main_valid <= 1'b1;
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign up_ready = ~r_skid_valid;
  assign dn_valid = r_main_valid;
  assign dn_data  = r_main_data;

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall_evt;

  assign w_stall_evt = r_main_valid & ~dn_ready;

  pipe_perf_cnt #(.CNT_W(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_stall_evt),
    .count (perf_stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(32)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush),
    .count (perf_flush_cnt)
  );
`endif

endmodule
`default_nettype wire
